// File: rtl/peripheral_gpio_filter_pkg.sv
// peripheral_gpio_filter_pkg
//   Shared defaults and types for the GPIO input filter.
//   - GPIO_FILTER_SYNC_STAGES    : default synchroniser depth (legal 2..4)
//   - GPIO_FILTER_DEBOUNCE_WIDTH : default width of the per-bit stability counter
//   - flt_action_e               : per-cycle decision taken by each filter bit
package peripheral_gpio_filter_pkg;

  localparam int unsigned GPIO_FILTER_SYNC_STAGES    = 2;
  localparam int unsigned GPIO_FILTER_DEBOUNCE_WIDTH = 16;

  localparam int unsigned GPIO_FILTER_SYNC_STAGES_MIN = 2;
  localparam int unsigned GPIO_FILTER_SYNC_STAGES_MAX = 4;

  // What a filter bit does with its filtered flop and counter this cycle.
  //   FltClear  : synchronised level equals filtered level, counter restarts
  //   FltCount  : level differs but has not been stable long enough yet
  //   FltUpdate : filtered flop takes the synchronised level
  typedef enum logic [1:0] {
    FltClear  = 2'b00,
    FltCount  = 2'b01,
    FltUpdate = 2'b10
  } flt_action_e;

  // True when a requested synchroniser depth is within the supported range.
  function automatic bit sync_stages_legal(int unsigned stages);
    return (stages >= GPIO_FILTER_SYNC_STAGES_MIN) && (stages <= GPIO_FILTER_SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/peripheral_gpio_filter_bit.sv
// peripheral_gpio_filter_bit
//   One pad bit: synchroniser chain, optional debounce, filtered level and
//   registered rise/fall pulses.
//   Ports:
//     clk_i, rst_ni        : clock, asynchronous active-low reset
//     pad_i                : raw asynchronous pad level
//     debounce_en_i        : 1 = debounce, 0 = bypass
//     debounce_limit_i     : stability threshold L in cycles
//     pad_o                : filtered level
//     rise_o, fall_o       : one-cycle pulses aligned with the first cycle of a new pad_o value
module peripheral_gpio_filter_bit
  import peripheral_gpio_filter_pkg::*;
#(
  parameter int unsigned SyncStages    = GPIO_FILTER_SYNC_STAGES,
  parameter int unsigned DebounceWidth = GPIO_FILTER_DEBOUNCE_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     pad_i,
  input  logic                     debounce_en_i,
  input  logic [DebounceWidth-1:0] debounce_limit_i,
  output logic                     pad_o,
  output logic                     rise_o,
  output logic                     fall_o
);

  localparam logic [DebounceWidth-1:0] CntOne = DebounceWidth'(1);

  logic [SyncStages-1:0]    sync_q, sync_d;
  logic                     f_q, f_d;
  logic [DebounceWidth-1:0] cnt_q, cnt_d;
  logic                     rise_q, rise_d;
  logic                     fall_q, fall_d;
  logic                     s;
  flt_action_e              action;

  // Oldest synchroniser stage is the only one the filter may look at.
  assign s = sync_q[SyncStages-1];

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pad_i};
  end

  // Decide this cycle's action. Bypass is simply "update whenever different";
  // debounce with L=0 collapses to the same thing because cnt_q >= 0 always holds.
  always_comb begin
    action = FltClear;
    if (s == f_q) begin
      action = FltClear;
    end else if (!debounce_en_i) begin
      action = FltUpdate;
    end else if (cnt_q >= debounce_limit_i) begin
      action = FltUpdate;
    end else begin
      action = FltCount;
    end
  end

  // Counter is zeroed on every update and L never exceeds its maximum value,
  // so the increment can never wrap.
  always_comb begin
    f_d    = f_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    unique case (action)
      FltClear: begin
        cnt_d = '0;
      end
      FltCount: begin
        cnt_d = cnt_q + CntOne;
      end
      FltUpdate: begin
        f_d    = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      f_q    <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      f_q    <= f_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign pad_o  = f_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/peripheral_gpio_input_filter.sv
// peripheral_gpio_input_filter
//   Conditions raw GPIO pads before they reach the GPIO register block:
//   per-bit synchronisation, optional debounce and edge-pulse generation.
//   Ports:
//     wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//     pad_i               : raw asynchronous pad inputs
//     debounce_en_i       : per-bit debounce enable (0 = bypass)
//     debounce_limit_i    : shared stability threshold L in cycles
//     pad_o               : filtered levels
//     rise_o, fall_o      : per-bit one-cycle edge pulses
//     change_o            : OR of every rise/fall pulse
module peripheral_gpio_input_filter
  import peripheral_gpio_filter_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH     = 32,
  parameter int unsigned SYNC_STAGES    = GPIO_FILTER_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_WIDTH = GPIO_FILTER_DEBOUNCE_WIDTH
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [GPIO_WIDTH-1:0]     pad_i,
  input  logic [GPIO_WIDTH-1:0]     debounce_en_i,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_limit_i,
  output logic [GPIO_WIDTH-1:0]     pad_o,
  output logic [GPIO_WIDTH-1:0]     rise_o,
  output logic [GPIO_WIDTH-1:0]     fall_o,
  output logic                      change_o
);

  // Out-of-range depths are clamped into the supported window rather than
  // producing a broken chain.
  localparam int unsigned SyncStagesUsed =
      sync_stages_legal(SYNC_STAGES)           ? SYNC_STAGES :
      (SYNC_STAGES < GPIO_FILTER_SYNC_STAGES_MIN) ? GPIO_FILTER_SYNC_STAGES_MIN :
                                                 GPIO_FILTER_SYNC_STAGES_MAX;

  for (genvar b = 0; b < GPIO_WIDTH; b++) begin : g_bit
    peripheral_gpio_filter_bit #(
      .SyncStages   (SyncStagesUsed),
      .DebounceWidth(DEBOUNCE_WIDTH)
    ) u_bit (
      .clk_i           (wb_clk_i),
      .rst_ni          (wb_rst_ni),
      .pad_i           (pad_i[b]),
      .debounce_en_i   (debounce_en_i[b]),
      .debounce_limit_i(debounce_limit_i),
      .pad_o           (pad_o[b]),
      .rise_o          (rise_o[b]),
      .fall_o          (fall_o[b])
    );
  end

  // Pulses are already registered, so this reduction is aligned with them.
  assign change_o = |{rise_o, fall_o};

endmodule

// File: tb/tb_peripheral_gpio_input_filter.sv
module tb_peripheral_gpio_input_filter;

  localparam int unsigned W    = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DW   = 16;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  pad_i;
  logic [W-1:0]  en_i;
  logic [DW-1:0] limit_i;
  logic [W-1:0]  pad_o;
  logic [W-1:0]  rise_o;
  logic [W-1:0]  fall_o;
  logic          change_o;

  int total = 0;
  int bad   = 0;

  peripheral_gpio_input_filter #(
    .GPIO_WIDTH    (W),
    .SYNC_STAGES   (SYNC),
    .DEBOUNCE_WIDTH(DW)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .pad_i           (pad_i),
    .debounce_en_i   (en_i),
    .debounce_limit_i(limit_i),
    .pad_o           (pad_o),
    .rise_o          (rise_o),
    .fall_o          (fall_o),
    .change_o        (change_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: s is the pad value seen SYNC edges earlier; a bit's level
  // moves to s once s has differed from it for more than L consecutive
  // evaluations (immediately when bypassed).
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_f, m_rise, m_fall;
  int unsigned  m_run [W];

  task automatic model_reset();
    m_hist = {};
    for (int k = 0; k < int'(SYNC); k++) m_hist.push_back('0);
    m_f    = '0;
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < int'(W); b++) m_run[b] = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        logic [W-1:0] s;
        logic [W-1:0] nf;
        s  = m_hist[SYNC-1];
        nf = m_f;
        for (int b = 0; b < int'(W); b++) begin
          if (s[b] == m_f[b]) begin
            m_run[b] = 0;
          end else if (!en_i[b] || m_run[b] >= int'(limit_i)) begin
            nf[b]    = s[b];
            m_run[b] = 0;
          end else begin
            m_run[b] = m_run[b] + 1;
          end
        end
        m_rise = nf & ~m_f;
        m_fall = m_f & ~nf;
        m_f    = nf;
        m_hist.push_front(pad_i);
        void'(m_hist.pop_back());
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("pad_o_model", pad_o, m_f);
      chk("rise_o_model", rise_o, m_rise);
      chk("fall_o_model", fall_o, m_fall);
      chk("change_o_model", {31'b0, change_o}, {31'b0, |(m_rise | m_fall)});
      chk("rise_fall_exclusive", rise_o & fall_o, '0);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // ---------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    pad_i   = 32'hFFFF_FFFF;
    en_i    = '0;
    limit_i = '0;

    // Reset with all pads high.
    step(3);
    chk("reset_pad_o", pad_o, '0);
    chk("reset_rise_o", rise_o, '0);
    chk("reset_change_o", {31'b0, change_o}, '0);
    rst_n = 1'b1;
    step(2);
    chk("rel_e2_pad_o", pad_o, '0);
    step(1);
    chk("rel_e3_pad_o", pad_o, 32'hFFFF_FFFF);
    chk("rel_e3_rise_o", rise_o, 32'hFFFF_FFFF);
    chk("rel_e3_change_o", {31'b0, change_o}, 32'd1);
    step(1);
    chk("rel_e4_rise_o", rise_o, '0);
    chk("rel_e4_change_o", {31'b0, change_o}, '0);

    // Bypass latency on bit 0.
    pad_i = '0;
    step(6);
    chk("byp_low_pad_o", pad_o, '0);
    pad_i[0] = 1'b1;
    step(2);
    chk("byp_rise_e1", pad_o, '0);
    step(1);
    chk("byp_rise_e2_pad", pad_o, 32'h1);
    chk("byp_rise_e2_pulse", rise_o, 32'h1);
    step(1);
    chk("byp_rise_e3_pulse", rise_o, '0);
    pad_i[0] = 1'b0;
    step(2);
    chk("byp_fall_e1", pad_o, 32'h1);
    step(1);
    chk("byp_fall_e2_pad", pad_o, '0);
    chk("byp_fall_e2_pulse", fall_o, 32'h1);
    step(1);
    chk("byp_fall_e3_pulse", fall_o, '0);

    // Back-to-back bypass updates on bit 6.
    for (int i = 0; i < 8; i++) begin
      pad_i[6] = ~pad_i[6];
      step(1);
    end
    step(4);

    // Glitch rejection on bit 5, L=4.
    en_i[5] = 1'b1;
    limit_i = 16'd4;
    pad_i[5] = 1'b1;
    step(4);
    pad_i[5] = 1'b0;
    step(10);
    chk("glitch4_pad_o", pad_o & 32'h20, '0);
    pad_i[5] = 1'b1;
    step(6);
    chk("pulse6_e5", pad_o & 32'h20, '0);
    pad_i[5] = 1'b0;
    step(1);
    chk("pulse6_e6_pad", pad_o & 32'h20, 32'h20);
    chk("pulse6_e6_rise", rise_o, 32'h20);
    step(12);
    chk("pulse6_back_low", pad_o & 32'h20, '0);

    // Bounce on bit 1, L=4: pattern 1,1,0,1,1,1,1,1.
    en_i[1] = 1'b1;
    pad_i[1] = 1'b1; step(1);
    pad_i[1] = 1'b1; step(1);
    pad_i[1] = 1'b0; step(1);
    pad_i[1] = 1'b1;
    step(6);
    chk("bounce_e5", pad_o & 32'h2, '0);
    step(1);
    chk("bounce_e6_pad", pad_o & 32'h2, 32'h2);
    chk("bounce_e6_rise", rise_o, 32'h2);
    step(3);

    // L change mid-count on bit 2.
    en_i[2] = 1'b1;
    limit_i = 16'd100;
    pad_i[2] = 1'b1;
    step(22);
    chk("lchg_before", pad_o & 32'h4, '0);
    limit_i = 16'd10;
    step(1);
    chk("lchg_after_pad", pad_o & 32'h4, 32'h4);
    chk("lchg_after_rise", rise_o, 32'h4);
    step(1);
    chk("lchg_single_pulse", rise_o, '0);

    // Enable drop mid-count on bit 3.
    en_i[3] = 1'b1;
    limit_i = 16'd100;
    pad_i[3] = 1'b1;
    step(10);
    chk("endrop_before", pad_o & 32'h8, '0);
    en_i[3] = 1'b0;
    step(1);
    chk("endrop_after", pad_o & 32'h8, 32'h8);
    chk("endrop_rise", rise_o, 32'h8);

    // Reset mid-count on bit 4.
    en_i[4] = 1'b1;
    pad_i[4] = 1'b1;
    step(10);
    chk("rstmid_before", pad_o & 32'h10, '0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_pad_o", pad_o, '0);
    chk("rstmid_pulses", rise_o | fall_o, '0);
    step(2);
    rst_n = 1'b1;
    // Bit 4 must restart its count from zero: 2 sync + 101 more edges.
    step(102);
    chk("rstmid_restart_low", pad_o & 32'h10, '0);
    step(1);
    chk("rstmid_restart_high", pad_o & 32'h10, 32'h10);
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
